// File: rtl/mio_bus_ctrl_pkg.sv
// Shared definitions for the MIO bus controller: FSM state encodings and the
// fill bit used to build the data word returned on a bus error.
package mio_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_DONE   = 3'd2,
    ST_ERR    = 3'd3
  } mio_state_t;

  // Every bit of Data_to_cpu takes this value on a timed-out access.
  localparam logic ERR_FILL = 1'b1;

endpackage

// File: rtl/mio_bus_ctrl_if.sv
// CPU-side request/response and peripheral-channel signals of the MIO bus.
// Handshake: CPU_MIO is a level request, held with mem_w/Addr_in/Data_in stable
// until the one-cycle MIO_ready pulse; a channel finishes by pulsing its ch_ack bit.
interface mio_bus_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int N_CH   = 4
);

  logic                   CPU_MIO;
  logic                   mem_w;
  logic [ADDR_W-1:0]      Addr_in;
  logic [DATA_W-1:0]      Data_in;
  logic                   MIO_ready;
  logic [DATA_W-1:0]      Data_to_cpu;
  logic                   bus_err;
  logic [N_CH-1:0]        ch_sel;
  logic                   ch_we;
  logic [ADDR_W-1:0]      ch_addr;
  logic [DATA_W-1:0]      ch_wdata;
  logic [N_CH*DATA_W-1:0] ch_rdata;
  logic [N_CH-1:0]        ch_ack;

  modport slave (
    input  CPU_MIO, mem_w, Addr_in, Data_in, ch_rdata, ch_ack,
    output MIO_ready, Data_to_cpu, bus_err, ch_sel, ch_we, ch_addr, ch_wdata
  );

  modport master (
    output CPU_MIO, mem_w, Addr_in, Data_in, ch_rdata, ch_ack,
    input  MIO_ready, Data_to_cpu, bus_err, ch_sel, ch_we, ch_addr, ch_wdata
  );

endinterface

// File: rtl/mio_wait_cnt.sv
// Saturating wait counter for one bus access, with compares against the
// channel's minimum wait and the fixed no-ack timeout.
module mio_wait_cnt #(
  parameter int WAIT_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [WAIT_W-1:0] min_wait,
  output logic [WAIT_W-1:0] cnt,
  output logic              min_met,
  output logic              at_timeout
);

  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign min_met    = (cnt >= min_wait);
  assign at_timeout = (cnt == TIMEOUT_V);

endmodule

// File: rtl/mio_bus_ctrl.sv
// MIO bus controller: latches one CPU request, routes it to the channel chosen by
// the top address bits, waits for that channel's ack (or times out) and replies.
module mio_bus_ctrl
  import mio_bus_ctrl_pkg::*;
#(
  parameter int                       ADDR_W   = 32,
  parameter int                       DATA_W   = 32,
  parameter int                       N_CH     = 4,
  parameter int                       WAIT_W   = 4,
  parameter logic [N_CH*WAIT_W-1:0]   MIN_WAIT = '0,
  parameter int                       TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             reset,
  mio_bus_ctrl_if.slave    bus,
  output logic [2:0]       state
);

  localparam int CH_W = $clog2(N_CH);

  mio_state_t        cur, nxt;
  logic [CH_W-1:0]   ch_idx;
  logic              we_q;
  logic              ack_seen;
  logic [DATA_W-1:0] rdata_cap;
  logic [DATA_W-1:0] rdata_now;
  logic [WAIT_W-1:0] min_wait_sel;
  logic [WAIT_W-1:0] wcnt;
  logic              ack_now;
  logic              min_met;
  logic              at_timeout;

  assign min_wait_sel = MIN_WAIT[ch_idx*WAIT_W +: WAIT_W];
  assign rdata_now    = bus.ch_rdata[ch_idx*DATA_W +: DATA_W];
  // Acks from channels other than the latched one never reach the FSM.
  assign ack_now      = (cur == ST_ACCESS) && bus.ch_ack[ch_idx];
  assign state        = cur;

  mio_wait_cnt #(
    .WAIT_W  (WAIT_W),
    .TIMEOUT (TIMEOUT)
  ) u_wait_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr        (cur == ST_IDLE),
    .en         (cur == ST_ACCESS),
    .min_wait   (min_wait_sel),
    .cnt        (wcnt),
    .min_met    (min_met),
    .at_timeout (at_timeout)
  );

  always_comb begin
    nxt = cur;
    unique case (cur)
      ST_IDLE:   if (bus.CPU_MIO) nxt = ST_ACCESS;
      // An ack arriving on the timeout cycle still completes normally.
      ST_ACCESS: begin
        if ((ack_now || ack_seen) && min_met)       nxt = ST_DONE;
        else if (!(ack_now || ack_seen) && at_timeout) nxt = ST_ERR;
      end
      ST_DONE:   nxt = ST_IDLE;
      ST_ERR:    nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ch_sel = '0;
    if (cur == ST_ACCESS) bus.ch_sel[ch_idx] = 1'b1;
  end

  assign bus.ch_we = we_q && (cur == ST_ACCESS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur             <= ST_IDLE;
      bus.MIO_ready   <= 1'b0;
      bus.bus_err     <= 1'b0;
      bus.ch_addr     <= '0;
      bus.ch_wdata    <= '0;
      bus.Data_to_cpu <= '0;
      we_q            <= 1'b0;
      ch_idx          <= '0;
      ack_seen        <= 1'b0;
      rdata_cap       <= '0;
    end else begin
      cur           <= nxt;
      bus.MIO_ready <= (nxt == ST_DONE) || (nxt == ST_ERR);
      bus.bus_err   <= (nxt == ST_ERR);
      if ((cur == ST_IDLE) && bus.CPU_MIO) begin
        we_q         <= bus.mem_w;
        bus.ch_addr  <= bus.Addr_in;
        bus.ch_wdata <= bus.Data_in;
        ch_idx       <= bus.Addr_in[ADDR_W-1 -: CH_W];
        ack_seen     <= 1'b0;
      end
      if (ack_now) begin
        ack_seen  <= 1'b1;
        rdata_cap <= rdata_now;
      end
      // Response data is loaded on entry to DONE/ERR so it is valid with MIO_ready.
      if ((cur == ST_ACCESS) && (nxt == ST_DONE) && !we_q) begin
        bus.Data_to_cpu <= ack_now ? rdata_now : rdata_cap;
      end else if (nxt == ST_ERR) begin
        bus.Data_to_cpu <= {DATA_W{ERR_FILL}};
      end
    end
  end

endmodule
